// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmitter FSM states and the frame builder.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data MSB.
package uart_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } uart_tx_state_t;

  localparam int UART_WORD_W = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_OVERHEAD = 3;
`else
  localparam int FRAME_OVERHEAD = 2;
`endif

  localparam int FRAME_W = UART_WORD_W + FRAME_OVERHEAD;

  // Bit 0 is the start bit, so shifting the frame right emits it in line order.
  function automatic logic [FRAME_W-1:0] frame_word(input logic [UART_WORD_W-1:0] word);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^word, word, 1'b0};
`else
    return {1'b1, word, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/uart_tx_axis_if.sv
// AXI-Stream beat carrier feeding the UART transmitter; word i of a beat is s_data[i].
interface uart_tx_axis_if #(
  parameter int WORD_W         = 8,
  parameter int WORDS_PER_BEAT = 1
);

  logic                                   s_valid;
  logic                                   s_ready;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/uart_tx_axis.sv
// AXI-Stream to UART transmitter: each beat is sent as contiguous frames, word 0 first.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit into every frame.
module uart_tx_axis
  import uart_pkg::*;
#(
  parameter int WORD_W           = 8,
  parameter int BUS_W            = 8,
  parameter int CLOCKS_PER_PULSE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_axis_if.slave  s,
  output logic           tx,
  output logic           busy
);

  localparam int WORDS_PER_BEAT = BUS_W / WORD_W;
  localparam int FRAME_BITS     = WORD_W + FRAME_OVERHEAD;
  localparam int BEAT_BITS      = WORDS_PER_BEAT * FRAME_BITS;
  localparam int PULSE_W        = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W          = $clog2(BEAT_BITS + 1);

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BEAT_BITS);

  uart_tx_state_t state, state_next;

  logic [BEAT_BITS-1:0]                          shreg, shreg_next;
  logic [PULSE_W-1:0]                            pulse_cnt, pulse_next;
  logic [BIT_W-1:0]                              bit_cnt, bit_next;
  logic                                          ready_q;
  logic [WORDS_PER_BEAT-1:0][FRAME_BITS-1:0]     frames;

  assign s.s_ready = ready_q;

  // Packed frame array lands word 0 in the shift register LSBs.
  for (genvar i = 0; i < WORDS_PER_BEAT; i++) begin : g_frame
    if (WORD_W == UART_WORD_W) begin : g_pkg
      assign frames[i] = frame_word(s.s_data[i]);
    end else begin : g_generic
`ifdef UART_TX_PARITY_EN
      assign frames[i] = {1'b1, ^s.s_data[i], s.s_data[i], 1'b0};
`else
      assign frames[i] = {1'b1, s.s_data[i], 1'b0};
`endif
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_next = state;
    shreg_next = shreg;
    pulse_next = pulse_cnt;
    bit_next   = bit_cnt;

    case (state)
      IDLE: begin
        if (s.s_valid && ready_q) begin
          state_next = SEND;
          shreg_next = frames;
          pulse_next = '0;
          bit_next   = '0;
        end
      end
      SEND: begin
        if (pulse_cnt == PULSE_LAST) begin
          pulse_next = '0;
          shreg_next = {1'b1, shreg[BEAT_BITS-1:1]};
          bit_next   = bit_cnt + 1'b1;
          if (bit_next == BIT_LAST) state_next = IDLE;
        end else begin
          pulse_next = pulse_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shift register is cleared too, so an aborted beat can never leak bits into the next one.
      state     <= IDLE;
      shreg     <= '0;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
      state     <= state_next;
      shreg     <= shreg_next;
      pulse_cnt <= pulse_next;
      bit_cnt   <= bit_next;
      // tx mirrors the bit that the shift register will present after this edge.
      tx        <= (state_next == SEND) ? shreg_next[0] : 1'b1;
      ready_q   <= (state_next == IDLE);
      busy      <= (state_next == SEND);
    end
  end

endmodule

// File: doc/uart_tx_axis.md
# uart_tx_axis

AXI-Stream-to-UART transmitter. It accepts beats of `WORDS_PER_BEAT` words on an AXIS slave port and serializes each word as an 8N1-style UART frame on a single `tx` line, with word 0 sent first. It is the output end of the UART matrix-vector datapath: result beats from the core stream in, and serial bytes go out to the host.

## Interface
Parameters:
- `WORD_W`, 8: bits per UART data word.
- `BUS_W`, 8: AXIS data width. It must be a multiple of `WORD_W`.
- `WORDS_PER_BEAT`, `BUS_W/WORD_W`: localparam giving the number of words per beat.
- `CLOCKS_PER_PULSE`, 4: clock cycles per UART bit. It must be ≥ 2.

Ports:
- `clk`, in, 1: the single clock. Everything is on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `s_valid`, in, 1: AXIS valid.
- `s_ready`, out, 1: AXIS ready. Registered.
- `s_data`, in, `WORDS_PER_BEAT×WORD_W` (packed `[WORDS_PER_BEAT-1:0][WORD_W-1:0]`): word i is `s_data[i]`.
- `tx`, out, 1: UART line. Idles high. Registered.
- `busy`, out, 1: high while a beat is being serialized. Equal to `!s_ready` after reset.

## Operation
- Frame per word: start bit (0), then `WORD_W` data bits LSB first, then [parity], then stop bit (1). `FRAME_W` = `WORD_W`+2 (+1 with parity).
- The FSM has two states, IDLE and SEND.
- **IDLE**
  - `s_ready`=1 and `tx`=1.
  - A handshake is `s_valid && s_ready` at a posedge.
  - On a handshake, load the shift register with the concatenated frames of all words, word 0 in the LSBs. Clear the pulse and bit counters. Go to SEND with `s_ready`=0.
- **SEND**
  - `tx` = `shreg[0]` (registered copy).
  - The pulse counter counts 0..`CLOCKS_PER_PULSE`-1.
  - On terminal count, shift right by 1 (fill with 1) and increment the bit counter.
  - When the bit counter reaches `WORDS_PER_BEAT×FRAME_W` at terminal count, go to IDLE and set `s_ready`=1 the same edge.
- Frames within a beat are contiguous. There are no idle bits between words.
- `s_data` is sampled only at the handshake edge. It is ignored (it may be X) at all other times.
- `s_valid` held high continuously gives back-to-back beats with no idle gap: a new start bit directly follows the last stop bit.
- `s_valid` may drop without a handshake, and the block simply stays in IDLE. The block never drops `s_ready` in IDLE.
- Counter widths: pulse counter `$clog2(CLOCKS_PER_PULSE)`, bit counter `$clog2(WORDS_PER_BEAT×FRAME_W+1)`. No wrap inside a beat.

## Timing
- **Reset:** any edge with `rst_n`=0 forces IDLE, `tx`=1, `s_ready`=0, `busy`=0, and clears the counters and shift register.
  - `s_ready` rises on the first edge where `rst_n`=1.
  - Reset mid-frame aborts the beat. `tx` is 1 on the very next cycle, and the partial beat is discarded.
- **Handshake at edge T:**
  - The start bit is on `tx` from T+1 for `CLOCKS_PER_PULSE` cycles.
  - Each following bit lasts exactly `CLOCKS_PER_PULSE` cycles.
- **Beat duration:** the last stop bit ends, and `s_ready` rises, at edge T + `WORDS_PER_BEAT×FRAME_W×CLOCKS_PER_PULSE`.
- **Throughput:** one beat per `WORDS_PER_BEAT×FRAME_W×CLOCKS_PER_PULSE` + 1 cycles. The +1 is the handshake cycle, during which `tx` shows the previous stop bit (1).

## Configuration
- `UART_TX_PARITY_EN`
  - **Defined:** an even-parity bit (XOR of the data bits) is inserted after data bit MSB and before the stop bit, and `FRAME_W` = `WORD_W`+3.
  - **Undefined:** there is no parity bit, and `FRAME_W` = `WORD_W`+2.
  - All beat-duration figures scale with `FRAME_W`.

## Structure
- Shared package `uart_pkg`:
  - `localparam FRAME_W`, under the same macro.
  - FSM enum `uart_tx_state_t` {IDLE, SEND}.
  - Function `frame_word(word)` returning the `FRAME_W`-bit frame, LSB = start bit.
- There is no sub-module. The pulse counter, bit counter and shift register are inline in `uart_tx_axis`.

## Test plan
All scenarios use `WORD_W`=8, `BUS_W`=16, `CLOCKS_PER_PULSE`=4, parity off (`FRAME_W`=10) unless noted.
1. **Reset values:** hold `rst_n`=0 for 3 cycles → `tx`=1 and `s_ready`=0 throughout. `s_ready`=1 on the first edge after release.
2. **Single beat:** `s_data`={8'h3C, 8'hA5} handshake at T → `tx` samples mid-bit read 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1. `s_ready` rises at T+80.
3. **Back-to-back:** `s_valid` held 1 for 3 beats → 3×80 bit-cycles of frames with exactly one extra stop-level cycle between beats. No start bit is lost.
4. **Random valid:** AXIS source with 20% valid probability, X on data when not valid, 10 beats → the decoded byte stream equals the input. No X ever appears on `tx`.
5. **Reset mid-frame:** assert `rst_n`=0 at bit 5 of word 0 → `tx`=1 next cycle. The next beat after release transmits cleanly from its start bit.
6. **Parity on (`UART_TX_PARITY_EN`):** word 8'h07 → parity bit 1. Word 8'h03 → parity bit 0. The beat takes 88 cycles.
